// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one byte-wide AXI-Stream sink among NUM_SRC sources.
// Optional mid-packet stall timeout is enabled by defining ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e              state_q;
  logic [NUM_SRC-1:0]  grant_q;
  logic [IdxW-1:0]     last_q;
  logic                busy_q;

  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search last+1, last+2, ... wrapping, so the previous winner is checked last.
  logic            win_found;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = (cand == IdxW'(NUM_SRC - 1)) ? '0 : cand + 1'b1;
      if (!win_found && s_axis_tvalid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // While granted, last_q holds the granted index.
  logic g_valid;
  logic g_last;
  logic pkt_end;

  assign g_valid = s_axis_tvalid[last_q];
  assign g_last  = s_axis_tlast[last_q];
  assign pkt_end = (state_q == StGrant) && g_valid && g_last && m_axis_tready;

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == StGrant) begin
      m_axis_tdata          = src_data[last_q];
      m_axis_tvalid         = g_valid;
      m_axis_tlast          = g_last;
      s_axis_tready[last_q] = m_axis_tready;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] stall_q;
  logic            tout_q;

  assign timeout_err = tout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NUM_SRC - 1);
      busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      stall_q <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q <= StGrant;
            grant_q <= NUM_SRC'(1) << win_idx;
            last_q  <= win_idx;
            busy_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            stall_q <= '0;
`endif
          end
        end
        StGrant: begin
          if (pkt_end) begin
            state_q <= StIdle;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          // Only an absent source counts as a stall; sink backpressure does not.
          else if (!g_valid) begin
            if (stall_q == CntW'(TIMEOUT_CYCLES - 1)) begin
              state_q <= StIdle;
              grant_q <= '0;
              busy_q  <= 1'b0;
              stall_q <= '0;
              tout_q  <= 1'b1;
            end else begin
              stall_q <= stall_q + 1'b1;
            end
          end else begin
            stall_q <= '0;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule
